// File: rtl/gray_updown_counter.sv
// ----------------------------------------------------------------------------
// gray_updown_counter
//
// Parametrised up/down binary-reflected Gray counter with synchronous clear
// and load, wrap or saturate behaviour at the ends of the range, and status
// outputs for terminal count, wrap pulse and sticky overflow.
//
// The state is held as a Gray code. Each cycle it is converted back to binary
// with a prefix XOR from the MSB, stepped by +1 or -1, and re-encoded. An
// enable step therefore changes exactly one bit, including the wrap step.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2); sequence length 2^WIDTH
//   RESET_VAL  binary value restored by rst and clear (stored as Gray)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   enable      advance one step this cycle
//   up          direction: 1 = increment, 0 = decrement
//   mode_sat    1 = saturate at the end of range, 0 = wrap
//   clear       synchronous return to RESET_VAL (highest priority)
//   load        synchronous load of load_bin (beats enable)
//   load_bin    binary load value
//   ovf_clr     clears the sticky overflow flag (a same-cycle set wins)
//   grey_count  registered Gray count
//   tc          combinational terminal count for the current direction
//   wrap_pulse  registered, high for one cycle after a wrap step
//   overflow    registered sticky flag: wrap or blocked saturating step
//   bin_count   registered binary equivalent of grey_count
//               (present only when GREY_BIN_OUT_EN is defined)
//
// Optional feature macro: GREY_BIN_OUT_EN
// ----------------------------------------------------------------------------
module gray_updown_counter #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             mode_sat,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] grey_count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             overflow
`ifdef GREY_BIN_OUT_EN
    ,
    output logic [WIDTH-1:0] bin_count
`endif
);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GREY = RESET_BIN ^ (RESET_BIN >> 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    logic [WIDTH-1:0] grey_reg;
    logic             wrap_pulse_reg;
    logic             overflow_reg;

    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] grey_next;
    logic             wrap_pulse_next;
    logic             overflow_next;
    logic             at_end;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    assign bin_cur[WIDTH-1] = grey_reg[WIDTH-1];
    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_g2b
            assign bin_cur[gi] = bin_cur[gi+1] ^ grey_reg[gi];
        end
    endgenerate

    // Up end is all-ones binary (Gray 100..0), down end is zero.
    assign at_end   = up ? (&bin_cur) : ~(|bin_cur);
    assign tc       = at_end;
    // Modulo arithmetic makes the wrap fall out of the ordinary step.
    assign bin_step = up ? (bin_cur + ONE) : (bin_cur - ONE);

    always_comb begin
        bin_next        = bin_cur;
        wrap_pulse_next = 1'b0;
        overflow_next   = overflow_reg & ~ovf_clr;

        if (clear) begin
            bin_next      = RESET_BIN;
            overflow_next = 1'b0;
        end else if (load) begin
            bin_next = load_bin;
        end else if (enable) begin
            if (at_end) begin
                // A new overflow event overrides a same-cycle ovf_clr.
                overflow_next = 1'b1;
                if (!mode_sat) begin
                    bin_next        = bin_step;
                    wrap_pulse_next = 1'b1;
                end
            end else begin
                bin_next = bin_step;
            end
        end
    end

    // Holding re-encodes bin_cur, which reproduces grey_reg exactly.
    assign grey_next = to_gray(bin_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grey_reg       <= RESET_GREY;
            wrap_pulse_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            grey_reg       <= grey_next;
            wrap_pulse_reg <= wrap_pulse_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign grey_count = grey_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign overflow   = overflow_reg;

`ifdef GREY_BIN_OUT_EN
    logic [WIDTH-1:0] bin_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg <= RESET_BIN;
        end else begin
            bin_reg <= bin_next;
        end
    end

    assign bin_count = bin_reg;
`endif

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised up/down Gray-code counter; successor to the fixed-direction Gray counter in the compressor datapath.
- Adds direction control, synchronous load and clear, and selectable wrap/saturate modes.
- Adds terminal-count, wrap-pulse and sticky overflow status for unary/Gray compression stages and CDC pointer generation.
- The Gray sequence is always the binary-reflected Gray code of an internal binary count, so only one bit changes per step.

Parameters:
- WIDTH, 8, counter width in bits (>=2); sequence length 2^WIDTH.
- RESET_VAL, 0, binary value loaded on reset and on clear; stored as its Gray equivalent.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  advance one step this cycle
- up  input  1  direction: 1 = increment, 0 = decrement
- mode_sat  input  1  1 = saturate at end of range, 0 = wrap
- clear  input  1  synchronous return to RESET_VAL
- load  input  1  synchronous load of load_bin
- load_bin  input  WIDTH  binary load value; stored as bin ^ (bin >> 1)
- ovf_clr  input  1  clears the sticky overflow flag
- grey_count  output  WIDTH  registered Gray count
- tc  output  1  combinational terminal count for the current direction
- wrap_pulse  output  1  registered, high for one cycle after a wrap step
- overflow  output  1  registered sticky flag; set on a wrap or on a blocked saturating step

Behaviour:
- Reset (rst=1, asynchronous): grey_count = Gray(RESET_VAL); wrap_pulse = 0; overflow = 0. Reset has priority over everything and takes effect mid-operation immediately, without waiting for a clock edge.
- Per-cycle priority: clear > load > enable. With none of these asserted, grey_count holds.
- clear: grey_count <= Gray(RESET_VAL); wrap_pulse <= 0; overflow <= 0.
- load: grey_count <= Gray(load_bin); wrap_pulse <= 0; overflow unchanged. A simultaneous enable is ignored.
- enable step:
  - Internal binary b = Gray-to-binary(grey_count), computed combinationally as a prefix XOR from the MSB.
  - Next value is Gray(b+1) when up=1, Gray(b-1) when up=0, using modulo-2^WIDTH arithmetic.
  - Latency: one clock; the new value is visible on grey_count after the edge.
- End-of-range points: the up end is b = 2^WIDTH-1, i.e. Gray = MSB only (1000..0); the down end is b = 0.
- tc: 1 when (up and b = 2^WIDTH-1) or (!up and b = 0); otherwise 0. It depends only on current inputs and state, not on enable.
- Wrap mode (mode_sat=0), enable with tc=1:
  - Counter wraps: up goes to 0, down goes to 1000..0.
  - wrap_pulse = 1 for the following cycle only.
  - overflow set.
- Saturate mode (mode_sat=1), enable with tc=1:
  - grey_count holds.
  - overflow set.
  - wrap_pulse stays 0.
- wrap_pulse is 0 in every cycle not immediately following a wrap step, including cycles after hold, load or clear.
- overflow: cleared by clear or ovf_clr. If ovf_clr is asserted in the same cycle as a new overflow event, the set wins and overflow stays 1.
- Changing up or mode_sat takes effect in the same cycle; no pipeline state depends on them.
- Gray property: every enable step, including a wrap, changes exactly one bit of grey_count. Load, clear and reset are exempt.

Optional Feature:
- Macro: GREY_BIN_OUT_EN.
- Defined:
  - Adds output port bin_count [WIDTH-1:0]: the registered binary equivalent of grey_count.
  - Updated on the same edge as grey_count, so the two are always consistent.
  - Reset and clear set it to RESET_VAL.
- Undefined:
  - bin_count port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=4, reset then up=1, mode_sat=0, 16 enables -> grey_count steps 0000,0001,0011,0010,0110,... and reaches 1000 after 15 enables. The 16th enable gives 0000, wrap_pulse=1 for exactly one cycle, overflow=1.
- Saturate up: load_bin=15 (grey 1000), mode_sat=1, up=1, 3 enables -> grey_count stays 1000, tc=1, overflow=1, wrap_pulse never asserted.
- Down wrap: clear, up=0, mode_sat=0, enable -> grey_count=1000, wrap_pulse pulses; a second enable gives 1001 (binary 14).
- Priority: load_bin=5 with load=1 and enable=1 -> grey_count=0111. In the same cycle as a wrap event, assert ovf_clr -> overflow=1. Assert clear with load -> grey_count=Gray(RESET_VAL), overflow=0.
- Async reset mid-count: assert rst between clock edges while counting -> grey_count returns to 0000 immediately. Counting resumes from 0001 on the first enable after rst deasserts.
- Random enable/up/mode_sat for 10k cycles -> checker confirms a single-bit change per enable step, consistency with a binary reference model, and bin_count == Gray-to-binary(grey_count) when GREY_BIN_OUT_EN is defined.
